// File: rtl/pc_fetch_unit.sv
// -----------------------------------------------------------------------------
// pc_fetch_unit
//   Program-counter and instruction-fetch stage. Holds the architectural PC,
//   issues one outstanding fetch at a time over a req/gnt/rvalid handshake,
//   presents the fetched instruction to decode, and picks the next PC
//   (sequential, branch/jump target or trap vector) when the instruction
//   retires (instr_valid and not stall).
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   br_taken, br_target   branch decision and target, used on the retire edge
//   stall                 execute not ready; blocks retirement
//   imem_req, imem_addr   fetch request and address (held stable until gnt)
//   imem_gnt              memory accepted the request
//   imem_rvalid, imem_rdata  fetch data return
//   instr, instr_valid, pc, pc_plus4  instruction presented to decode
//   misalign_exc, exc_pc  one-cycle pulse on a misaligned taken target
//   instret               retired-instruction counter (wraps)
// -----------------------------------------------------------------------------
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] TRAP_PC  = 32'h0000_0100
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        misalign_exc,
  output logic [31:0] exc_pc,
  output logic [31:0] instret
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_WAIT  = 2'd2,
    S_VALID = 2'd3
  } state_t;

  state_t      state, state_nx;
  logic [31:0] pc_nx, pc_plus4_nx, instr_nx, addr_nx, exc_pc_nx, instret_nx;
  logic        valid_nx, req_nx, exc_nx;
  logic [31:0] target_pc;
  logic        target_mis;

  // Next-PC selection; only consumed on the retire edge.
  always_comb begin
    target_pc  = pc + 32'd4;
    target_mis = 1'b0;
    if (!br_taken) begin
      target_pc  = pc + 32'd4;
      target_mis = 1'b0;
    end else if (br_target[1:0] == 2'b00) begin
      target_pc  = br_target;
      target_mis = 1'b0;
    end else begin
      // Any non-word-aligned taken target vectors to the trap handler.
      target_pc  = TRAP_PC;
      target_mis = 1'b1;
    end
  end

  // FSM next-state and next-value logic for every registered output.
  always_comb begin
    state_nx    = state;
    pc_nx       = pc;
    pc_plus4_nx = pc_plus4;
    instr_nx    = instr;
    valid_nx    = instr_valid;
    req_nx      = imem_req;
    addr_nx     = imem_addr;
    exc_nx      = 1'b0;
    exc_pc_nx   = exc_pc;
    instret_nx  = instret;
    case (state)
      S_IDLE: begin
        state_nx = S_REQ;
        req_nx   = 1'b1;
        addr_nx  = pc;
        valid_nx = 1'b0;
      end
      S_REQ: begin
        // rvalid is ignored here, even if it arrives together with gnt.
        if (imem_gnt) begin
          state_nx = S_WAIT;
          req_nx   = 1'b0;
        end else begin
          req_nx   = 1'b1;
        end
      end
      S_WAIT: begin
        if (imem_rvalid) begin
          state_nx = S_VALID;
          instr_nx = imem_rdata;
          valid_nx = 1'b1;
        end else begin
          valid_nx = 1'b0;
        end
      end
      S_VALID: begin
        if (!stall) begin
          state_nx    = S_REQ;
          valid_nx    = 1'b0;
          instret_nx  = instret + 32'd1;
          pc_nx       = target_pc;
          pc_plus4_nx = target_pc + 32'd4;
          req_nx      = 1'b1;
          addr_nx     = target_pc;
          if (target_mis) begin
            exc_nx    = 1'b1;
            exc_pc_nx = pc;
          end else begin
            exc_nx    = 1'b0;
          end
        end else begin
          valid_nx = 1'b1;
        end
      end
      default: begin
        state_nx = S_IDLE;
        req_nx   = 1'b0;
        valid_nx = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      pc           <= RESET_PC;
      pc_plus4     <= RESET_PC + 32'd4;
      instr        <= NOP;
      instr_valid  <= 1'b0;
      imem_req     <= 1'b0;
      imem_addr    <= RESET_PC;
      misalign_exc <= 1'b0;
      exc_pc       <= 32'd0;
      instret      <= 32'd0;
    end else begin
      state        <= state_nx;
      pc           <= pc_nx;
      pc_plus4     <= pc_plus4_nx;
      instr        <= instr_nx;
      instr_valid  <= valid_nx;
      imem_req     <= req_nx;
      imem_addr    <= addr_nx;
      misalign_exc <= exc_nx;
      exc_pc       <= exc_pc_nx;
      instret      <= instret_nx;
    end
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
module tb_pc_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] TRAP_PC  = 32'h0000_0100;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        br_taken = 1'b0;
  logic [31:0] br_target = 32'd0;
  logic        stall = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'd0;
  logic [31:0] instr;
  logic        instr_valid;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        misalign_exc;
  logic [31:0] exc_pc;
  logic [31:0] instret;

  pc_fetch_unit dut (
    .clk(clk), .rst_n(rst_n), .br_taken(br_taken), .br_target(br_target),
    .stall(stall), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .instr(instr), .instr_valid(instr_valid), .pc(pc), .pc_plus4(pc_plus4),
    .misalign_exc(misalign_exc), .exc_pc(exc_pc), .instret(instret)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] instret;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] addr_q[$];
  logic [31:0] exc_q[$];

  int checks = 0;
  int errors = 0;

  // reference architectural state
  logic [31:0] model_pc = RESET_PC;
  logic [31:0] model_instret = 32'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full instruction: fetch handshake, optional stall, retire with branch info.
  task automatic do_fetch(input int gd, input int rd, input int sc, input bit junk_rv,
                          input bit take, input logic [31:0] tgt, input logic [31:0] data);
    exp_t        e;
    logic [31:0] npc;
    int          n;
    n = 0;
    while (!imem_req && n < 10) begin
      step();
      n++;
    end
    chk("req_seen", {31'd0, imem_req}, 32'd1);
    for (int i = 0; i < gd; i++) begin
      chk("valid_low_req", {31'd0, instr_valid}, 32'd0);
      step();
    end
    imem_gnt = 1'b1;
    if (junk_rv) begin
      imem_rvalid = 1'b1;
      imem_rdata  = ~data;
    end
    step();
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = $urandom;
    chk("req_drop_after_gnt", {31'd0, imem_req}, 32'd0);
    for (int i = 0; i < rd; i++) begin
      chk("valid_low_wait", {31'd0, instr_valid}, 32'd0);
      step();
    end
    imem_rvalid = 1'b1;
    imem_rdata  = data;
    e.pc = model_pc;
    e.instr = data;
    e.instret = model_instret;
    exp_q.push_back(e);
    step();
    imem_rvalid = 1'b0;
    imem_rdata  = $urandom;
    chk("valid_after_rvalid", {31'd0, instr_valid}, 32'd1);
    if (sc > 0) begin
      stall = 1'b1;
      for (int i = 0; i < sc; i++) begin
        br_taken  = 1'($urandom);
        br_target = $urandom;
        step();
      end
      stall = 1'b0;
    end
    br_taken  = take;
    br_target = tgt;
    if (!take) npc = model_pc + 32'd4;
    else if (tgt[1:0] == 2'b00) npc = tgt;
    else begin
      npc = TRAP_PC;
      exc_q.push_back(model_pc);
    end
    addr_q.push_back(npc);
    model_pc = npc;
    model_instret = model_instret + 32'd1;
    step();
    br_taken  = 1'($urandom);
    br_target = $urandom;
    chk("valid_low_after_retire", {31'd0, instr_valid}, 32'd0);
    chk("instret_after_retire", instret, model_instret);
  endtask

  // Monitor: pops expectations whenever the DUT presents a fetch, instruction or exception.
  logic        prev_req = 1'b0, prev_valid = 1'b0, prev_exc = 1'b0;
  logic [31:0] cur_addr = 32'd0;
  exp_t        cur;
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_req", {31'd0, imem_req}, 32'd0);
      chk("rst_addr", imem_addr, RESET_PC);
      chk("rst_instr", instr, NOP);
      chk("rst_valid", {31'd0, instr_valid}, 32'd0);
      chk("rst_pc", pc, RESET_PC);
      chk("rst_exc", {31'd0, misalign_exc}, 32'd0);
      chk("rst_exc_pc", exc_pc, 32'd0);
      chk("rst_instret", instret, 32'd0);
      prev_req = 1'b0;
      prev_valid = 1'b0;
      prev_exc = 1'b0;
    end else begin
      if (imem_req) begin
        if (!prev_req) begin
          if (addr_q.size() == 0) chk("unexpected_fetch", imem_addr, 32'hxxxx_xxxx);
          else begin
            cur_addr = addr_q.pop_front();
            chk("fetch_addr", imem_addr, cur_addr);
          end
        end else begin
          chk("fetch_addr_hold", imem_addr, cur_addr);
        end
      end
      if (instr_valid) begin
        if (!prev_valid) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_valid", instr, 32'hxxxx_xxxx);
            cur.pc = pc; cur.instr = 32'hxxxx_xxxx; cur.instret = instret;
          end else begin
            cur = exp_q.pop_front();
          end
        end
        chk("instr", instr, cur.instr);
        chk("pc", pc, cur.pc);
        chk("pc_plus4", pc_plus4, cur.pc + 32'd4);
        chk("instret", instret, cur.instret);
        chk("req_low_valid", {31'd0, imem_req}, 32'd0);
      end
      if (misalign_exc) begin
        chk("exc_pulse_width", {31'd0, prev_exc}, 32'd0);
        if (exc_q.size() == 0) chk("unexpected_exc", exc_pc, 32'hxxxx_xxxx);
        else chk("exc_pc", exc_pc, exc_q.pop_front());
      end
      prev_req = imem_req;
      prev_valid = instr_valid;
      prev_exc = misalign_exc;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] tgt;
    int          kind;
    addr_q.push_back(RESET_PC);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    // zero-wait sequential fetches of NOP
    for (int i = 0; i < 3; i++) do_fetch(0, 0, 0, 1'b0, 1'b0, 32'd0, NOP);
    chk("instret_three", instret, 32'd3);
    do_fetch(0, 0, 0, 1'b0, 1'b0, 32'd0, $urandom);                 // pc 0xC
    do_fetch(0, 0, 0, 1'b0, 1'b1, 32'h0000_0040, $urandom);         // pc 0x10 -> 0x40
    do_fetch(0, 0, 0, 1'b0, 1'b1, 32'h0000_0020, $urandom);         // pc 0x40 -> 0x20
    do_fetch(0, 0, 0, 1'b0, 1'b1, 32'h0000_0042, $urandom);         // pc 0x20 -> trap
    chk("trap_pc", pc, TRAP_PC);
    do_fetch(0, 0, 5, 1'b0, 1'b0, 32'd0, $urandom);                 // stall 5
    do_fetch(4, 1, 0, 1'b1, 1'b0, 32'd0, $urandom);                 // slow memory
    do_fetch(0, 0, 0, 1'b0, 1'b1, 32'hFFFF_FFFC, $urandom);
    do_fetch(0, 0, 0, 1'b0, 1'b0, 32'd0, $urandom);                 // wrap to 0
    chk("wrap_pc", pc, 32'd0);
    for (int i = 0; i < 40; i++) begin
      kind = int'($urandom_range(0, 3));
      tgt  = $urandom;
      tgt[0] = 1'b0;
      if (kind < 2) tgt[1] = 1'b0;
      do_fetch(int'($urandom_range(0, 3)), int'($urandom_range(0, 2)),
               int'($urandom_range(0, 3)), 1'($urandom), 1'($urandom), tgt, $urandom);
    end
    // reset while waiting for rvalid; a stale rvalid follows release
    while (!imem_req) step();
    imem_gnt = 1'b1;
    step();
    imem_gnt = 1'b0;
    rst_n = 1'b0;
    chk("exc_q_empty_at_reset", exc_q.size(), 32'd0);
    exp_q.delete();
    addr_q.delete();
    addr_q.push_back(RESET_PC);
    model_pc = RESET_PC;
    model_instret = 32'd0;
    step();
    step();
    rst_n = 1'b1;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hDEAD_BEEF;
    step();
    step();
    imem_rvalid = 1'b0;
    chk("stale_rvalid_req", {31'd0, imem_req}, 32'd1);
    chk("stale_rvalid_valid", {31'd0, instr_valid}, 32'd0);
    chk("stale_rvalid_addr", imem_addr, RESET_PC);
    for (int i = 0; i < 3; i++) do_fetch(0, 0, 0, 1'b0, 1'b0, 32'd0, $urandom);
    step();
    chk("exp_q_drained", exp_q.size(), 32'd0);
    chk("exc_q_drained", exc_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
